timer_irq_unit: RTL and testbench

- Parametrised successor to the single-timer logic in the peripheral block: N_CH independent 32-bit reload timers plus a prioritised interrupt controller.
- Memory-mapped in the peripheral window (address bit 30 set); driven by the CPU's rd/wr/addr/wdata bus.
- Produces a single irqout to Control.
- Adds per-channel one-shot mode, a global mask, and a priority-encoded interrupt ID.

---
 rtl/timer_irq_unit.sv | 208 ++++++++++++++++++++
 tb/tb_timer_irq_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_unit.sv
//-----------------------------------------------------------------------------
// timer_irq_unit
//
// N_CH independent 32-bit auto-reload timers with a prioritised interrupt
// controller, memory-mapped into the peripheral window.
//
// Register map (byte offsets from BASE_ADDR):
//   16*c + 0x0  TH       reload value of channel c
//   16*c + 0x4  TL       counter of channel c
//   16*c + 0x8  TCON     {28'b0, ONESHOT, PEND, IE, EN}
//   0xF0        IRQ_STAT read-only, bit c = PEND of channel c
//   0xF4        IRQ_MASK read/write, N_CH bits (1 = enabled)
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   rd       read strobe
//   wr       write strobe (already peripheral-qualified)
//   addr     byte address; addr[1:0] ignored
//   wdata    write data
//   rdata    combinational read data (0 when not reading a mapped register)
//   PC31     kernel-mode flag; 1 suppresses irqout
//   irqout   registered interrupt request
//   irq_id   registered lowest pending unmasked channel, 4'hF if none
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module timer_irq_unit #(
  parameter int          N_CH      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        PC31,
  output logic        irqout,
  output logic [3:0]  irq_id
);

  // Register selectors within a 16-byte block
  localparam logic [1:0] REG_TH    = 2'd0;
  localparam logic [1:0] REG_TL    = 2'd1;
  localparam logic [1:0] REG_TCON  = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  // Block index 15 holds the global registers; N_CH is capped at 15 so it
  // can never collide with a channel block.
  localparam logic [3:0] GLB_BLOCK = 4'hF;
  localparam logic [31:0] TL_MAX   = 32'hFFFF_FFFF;

  // Architectural state
  logic [N_CH-1:0][31:0] th_q,   th_d;
  logic [N_CH-1:0][31:0] tl_q,   tl_d;
  logic [N_CH-1:0]       en_q,   en_d;
  logic [N_CH-1:0]       ie_q,   ie_d;
  logic [N_CH-1:0]       pend_q, pend_d;
  logic [N_CH-1:0]       os_q,   os_d;
  logic [N_CH-1:0]       mask_q, mask_d;
  logic                  irqout_q, irqout_d;
  logic [3:0]            irq_id_q, irq_id_d;

  // Address decode
  logic            win_hit;
  logic [3:0]      blk_sel;
  logic [1:0]      reg_sel;
  logic            glb_hit;
  logic [N_CH-1:0] ch_hit;
  logic [N_CH-1:0] ovf;
  logic [N_CH-1:0] pend_vec;
  logic            unused_addr;

  // Lowest set index of a channel vector, 4'hF when empty. Scanning from the
  // top down lets the lowest index overwrite any higher one.
  function automatic logic [3:0] lowest_set(input logic [N_CH-1:0] v);
    logic [3:0] id;
    id = 4'hF;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (v[c]) id = 4'(c);
    end
    return id;
  endfunction

  assign win_hit     = (addr[31:8] == BASE_ADDR[31:8]);
  assign blk_sel     = addr[7:4];
  assign reg_sel     = addr[3:2];
  assign glb_hit     = win_hit && (blk_sel == GLB_BLOCK);
  assign unused_addr = ^addr[1:0];

  always_comb begin
    ch_hit = '0;
    ovf    = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_hit[c] = win_hit && (blk_sel == 4'(c));
      ovf[c]    = en_q[c] && (tl_q[c] == TL_MAX);
    end
  end

  // Next-state logic for the timer channels and the mask. Ordering inside a
  // channel encodes the collision rules: counting first, then the CPU write
  // (so a CPU write to TL or EN wins), then the hardware PEND set last (so
  // hardware wins over a software clear).
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    en_d   = en_q;
    ie_d   = ie_q;
    pend_d = pend_q;
    os_d   = os_q;
    mask_d = mask_q;

    for (int c = 0; c < N_CH; c++) begin
      if (en_q[c]) begin
        if (ovf[c]) begin
          tl_d[c] = th_q[c];
          if (os_q[c]) en_d[c] = 1'b0;
        end else begin
          tl_d[c] = tl_q[c] + 32'd1;
        end
      end

      if (wr && ch_hit[c]) begin
        case (reg_sel)
          REG_TH:   th_d[c] = wdata;
          REG_TL:   tl_d[c] = wdata;
          REG_TCON: begin
            en_d[c]   = wdata[0];
            ie_d[c]   = wdata[1];
            // Software may only clear PEND, never set it
            pend_d[c] = pend_q[c] & wdata[2];
            os_d[c]   = wdata[3];
          end
          default: ;
        endcase
      end

      if (ovf[c] && ie_q[c]) pend_d[c] = 1'b1;
    end

    if (wr && glb_hit && (reg_sel == REG_MASK)) begin
      mask_d = wdata[N_CH-1:0];
    end
  end

  // Interrupt outputs are derived from the registered PEND/MASK, giving one
  // cycle of latency from a PEND or PC31 change to irqout/irq_id.
  assign pend_vec = pend_q & mask_q;

  always_comb begin
    irq_id_d = lowest_set(pend_vec);
    irqout_d = (|pend_vec) & ~PC31;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q     <= '0;
      tl_q     <= '0;
      en_q     <= '0;
      ie_q     <= '0;
      pend_q   <= '0;
      os_q     <= '0;
      mask_q   <= '1;
      irqout_q <= 1'b0;
      irq_id_q <= 4'hF;
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      pend_q   <= pend_d;
      os_q     <= os_d;
      mask_q   <= mask_d;
      irqout_q <= irqout_d;
      irq_id_q <= irq_id_d;
    end
  end

  // Combinational read mux; anything unmapped reads as zero
  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_hit[c]) begin
          case (reg_sel)
            REG_TH:   rdata = th_q[c];
            REG_TL:   rdata = tl_q[c];
            REG_TCON: rdata = {28'h0, os_q[c], pend_q[c], ie_q[c], en_q[c]};
            default:  rdata = 32'h0;
          endcase
        end
      end
      if (glb_hit) begin
        case (reg_sel)
          REG_STAT: rdata = 32'(pend_q);
          REG_MASK: rdata = 32'(mask_q);
          default:  rdata = 32'h0;
        endcase
      end
    end
  end

  assign irqout = irqout_q;
  assign irq_id = irq_id_q;

endmodule

// File: tb/tb_timer_irq_unit.sv
`timescale 1ns/1ps

module tb_timer_irq_unit;

  localparam logic [31:0] B    = 32'h4000_0000;
  localparam logic [31:0] TH0  = B + 32'h00;
  localparam logic [31:0] TL0  = B + 32'h04;
  localparam logic [31:0] TC0  = B + 32'h08;
  localparam logic [31:0] TH1  = B + 32'h10;
  localparam logic [31:0] TL1  = B + 32'h14;
  localparam logic [31:0] TC1  = B + 32'h18;
  localparam logic [31:0] STAT = B + 32'hF0;
  localparam logic [31:0] MASK = B + 32'hF4;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        PC31;
  logic        irqout;
  logic [3:0]  irq_id;

  int n_checks;
  int n_errors;

  timer_irq_unit #(.N_CH(2), .BASE_ADDR(B)) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .PC31   (PC31),
    .irqout (irqout),
    .irq_id (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One bus write, landing on the next rising edge; returns 1ns after it
  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    rd   = 1'b1;
    #1;
    check(tag, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    PC31  = 1'b0;

    // Reset values
    #12;
    check("rst_irqout", 32'(irqout), 32'h0);
    check("rst_irq_id", 32'(irq_id), 32'hF);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    rd_chk("rst_th0",   TH0,  32'h0);
    rd_chk("rst_tl0",   TL0,  32'h0);
    rd_chk("rst_tc0",   TC0,  32'h0);
    rd_chk("rst_th1",   TH1,  32'h0);
    rd_chk("rst_tl1",   TL1,  32'h0);
    rd_chk("rst_tc1",   TC1,  32'h0);
    rd_chk("rst_mask",  MASK, 32'h3);
    rd_chk("rst_stat",  STAT, 32'h0);
    check("rst_irqout2", 32'(irqout), 32'h0);
    check("rst_irq_id2", 32'(irq_id), 32'hF);

    // Unmapped locations and rd=0
    wr_reg(B + 32'h20, 32'h1234_5678);
    rd_chk("unmap_ch2", B + 32'h20, 32'h0);
    rd_chk("unmap_f8",  B + 32'hF8, 32'h0);
    addr = MASK;
    #1;
    check("rd_low", rdata, 32'h0);

    // Channel 0 auto-reload
    wr_reg(TH0, 32'hFFFF_FFFC);
    wr_reg(TL0, 32'hFFFF_FFFC);
    wr_reg(TC0, 32'h3);
    tick(3);
    rd_chk("c0_tl_pre",  TL0, 32'hFFFF_FFFF);
    rd_chk("c0_tc_pre",  TC0, 32'h3);
    tick(1);
    rd_chk("c0_tl_ovf",  TL0, 32'hFFFF_FFFC);
    rd_chk("c0_tc_ovf",  TC0, 32'h7);
    check("c0_irq_lat", 32'(irqout), 32'h0);
    tick(1);
    check("c0_irqout", 32'(irqout), 32'h1);
    check("c0_irq_id", 32'(irq_id), 32'h0);
    tick(2);
    rd_chk("c0_tl_ff2",  TL0, 32'hFFFF_FFFF);
    tick(1);
    rd_chk("c0_tl_ovf2", TL0, 32'hFFFF_FFFC);
    wr_reg(TC0, 32'h4);  // stop channel 0, keep PEND
    rd_chk("c0_tc_stop", TC0, 32'h4);

    // Channel 1 one-shot
    wr_reg(TH1, 32'hFFFF_FFFE);
    wr_reg(TL1, 32'hFFFF_FFFE);
    wr_reg(TC1, 32'hB);
    tick(1);
    rd_chk("c1_tl_ff",  TL1, 32'hFFFF_FFFF);
    tick(1);
    rd_chk("c1_tc_os",  TC1, 32'hE);
    rd_chk("c1_tl_os",  TL1, 32'hFFFF_FFFE);
    rd_chk("c1_stat",   STAT, 32'h3);
    tick(3);
    rd_chk("c1_tl_hold", TL1, 32'hFFFF_FFFE);

    // Priority and mask
    check("pri_id0", 32'(irq_id), 32'h0);
    wr_reg(MASK, 32'h2);
    tick(1);
    check("mask2_id", 32'(irq_id), 32'h1);
    check("mask2_irq", 32'(irqout), 32'h1);
    wr_reg(MASK, 32'h0);
    tick(1);
    check("mask0_irq", 32'(irqout), 32'h0);
    check("mask0_id",  32'(irq_id), 32'hF);
    rd_chk("mask0_stat", STAT, 32'h3);
    wr_reg(MASK, 32'h3);
    tick(1);
    check("mask3_irq", 32'(irqout), 32'h1);

    // Kernel gating and clearing
    @(negedge clk);
    PC31 = 1'b1;
    tick(1);
    check("k_gate_irq", 32'(irqout), 32'h0);
    check("k_gate_id",  32'(irq_id), 32'h0);
    @(negedge clk);
    PC31 = 1'b0;
    tick(1);
    check("k_ungate", 32'(irqout), 32'h1);
    wr_reg(TC0, 32'h0);
    rd_chk("clr0_tc", TC0, 32'h0);
    tick(1);
    check("clr0_irq", 32'(irqout), 32'h1);
    check("clr0_id",  32'(irq_id), 32'h1);
    wr_reg(TC1, 32'h8);
    check("clr1_lat", 32'(irqout), 32'h1);
    tick(1);
    check("clr1_irq", 32'(irqout), 32'h0);
    check("clr1_id",  32'(irq_id), 32'hF);

    // One-shot overflow vs CPU write of EN=1: CPU wins
    wr_reg(TL1, 32'hFFFF_FFFF);
    wr_reg(TC1, 32'hB);
    wr_reg(TC1, 32'hB);
    rd_chk("os_en_win", TC1, 32'hF);
    rd_chk("os_en_tl",  TL1, 32'hFFFF_FFFE);
    wr_reg(TC1, 32'h0);

    // TCON clear on the overflow edge: hardware set wins
    wr_reg(TH0, 32'h100);
    wr_reg(TL0, 32'hFFFF_FFFE);
    wr_reg(TC0, 32'h3);
    tick(1);
    wr_reg(TC0, 32'h3);
    rd_chk("col_pend", TC0, 32'h7);
    rd_chk("col_rld",  TL0, 32'h100);

    // TL write on the overflow edge: CPU value stored, PEND still set
    wr_reg(TL0, 32'hFFFF_FFFE);
    wr_reg(TC0, 32'h3);
    rd_chk("col_clr", TC0, 32'h3);
    wr_reg(TL0, 32'h10);
    rd_chk("col_tl",   TL0, 32'h10);
    rd_chk("col_tlp",  TC0, 32'h7);
    tick(1);
    rd_chk("col_cnt",  TL0, 32'h11);
    tick(1);
    check("pre_rst_irq", 32'(irqout), 32'h1);

    // Asynchronous reset mid-count
    #2;
    reset = 1'b0;
    #1;
    check("arst_irq", 32'(irqout), 32'h0);
    check("arst_id",  32'(irq_id), 32'hF);
    rd_chk("arst_tl0",  TL0,  32'h0);
    rd_chk("arst_th0",  TH0,  32'h0);
    rd_chk("arst_tc0",  TC0,  32'h0);
    rd_chk("arst_th1",  TH1,  32'h0);
    rd_chk("arst_mask", MASK, 32'h3);
    rd_chk("arst_stat", STAT, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    rd_chk("post_rst_tl0", TL0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
